// File: rtl/proj_pkg.sv
// Shared constants for the extender/collector pair, plus the one-hot base decode table.
package proj_pkg;
    localparam int FRAG_LEN_BITS     = 256;
    localparam int FRAG_SIZE         = 128;
    localparam int KMER_SIZE         = 16;
    localparam int FRAG_PART         = 32;
    localparam int BASE_LEN          = 2;
    localparam int ONE_HOT_LEN       = 4;
    localparam int FRAG_PART_ONE_HOT = FRAG_PART / BASE_LEN * ONE_HOT_LEN;
    localparam int INDICE_LEN        = 10;
    localparam int SIGNED_INDICE_LEN = INDICE_LEN + 1;
    localparam int BASES_PER_PART    = FRAG_PART / BASE_LEN;

    localparam int EXTENDER_INDEX_OFFSET = (FRAG_SIZE - KMER_SIZE) >> 1;
    localparam int EXTENDER_PARTS_COUNT  = FRAG_LEN_BITS / FRAG_PART;
    localparam int PART_CNT_W            = $clog2(EXTENDER_PARTS_COUNT);

    // Returns {valid, base}; anything that is not exactly one-hot is flagged and maps to base 00.
    function automatic logic [2:0] onehot_to_base(input logic [3:0] nib);
        logic [2:0] res;
        case (nib)
            4'b0001: res = 3'b100;
            4'b0010: res = 3'b101;
            4'b0100: res = 3'b110;
            4'b1000: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction
endpackage

// File: rtl/proj_onehot_part_decoder.sv
// Combinational decode of one one-hot fragment part into packed 2-bit bases.
module proj_onehot_part_decoder
    import proj_pkg::*;
(
    input  logic [FRAG_PART_ONE_HOT-1:0] in_onehot,
    output logic [FRAG_PART-1:0]         out_bits,
    output logic                         out_invalid
);
    logic [BASES_PER_PART-1:0] nib_ok;

    for (genvar j = 0; j < BASES_PER_PART; j++) begin : g_nib
        logic [2:0] dec;
        assign dec                             = onehot_to_base(in_onehot[ONE_HOT_LEN*j +: ONE_HOT_LEN]);
        assign nib_ok[j]                       = dec[2];
        assign out_bits[BASE_LEN*j +: BASE_LEN] = dec[1:0];
    end

    assign out_invalid = ~&nib_ok;
endmodule

// File: rtl/proj_gfm_collector.sv
// Reassembles one-hot fragment parts into a packed fragment, recovers the k-mer index,
// and presents the result through a one-entry valid/ready output register.
module proj_gfm_collector
    import proj_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FRAG_PART_ONE_HOT-1:0]        in_gfm,
    input  logic signed [SIGNED_INDICE_LEN-1:0] in_index,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [FRAG_LEN_BITS-1:0]            out_fragment,
    output logic [INDICE_LEN-1:0]               out_index,
    output logic                                out_err,
    output logic [15:0]                         out_frag_count
);
    localparam logic [PART_CNT_W-1:0] LAST_PART = PART_CNT_W'(EXTENDER_PARTS_COUNT - 1);
    localparam logic signed [SIGNED_INDICE_LEN-1:0] IDX_OFS =
        SIGNED_INDICE_LEN'(EXTENDER_INDEX_OFFSET);

    logic [PART_CNT_W-1:0]               part_q, part_d;
    logic [FRAG_LEN_BITS-1:0]            asm_q, asm_d;
    logic [INDICE_LEN-1:0]               idx_q, idx_d;
    logic signed [SIGNED_INDICE_LEN-1:0] ref_idx_q, ref_idx_d;
    logic                                err_q, err_d;
    logic                                out_valid_q, out_valid_d;
    logic [FRAG_LEN_BITS-1:0]            out_fragment_q, out_fragment_d;
    logic [INDICE_LEN-1:0]               out_index_q, out_index_d;
    logic                                out_err_q, out_err_d;
    logic [15:0]                         out_frag_count_q, out_frag_count_d;

    logic [FRAG_PART-1:0]                part_bits;
    logic                                part_bad;
    logic signed [SIGNED_INDICE_LEN-1:0] idx_sum;
    logic                                accept;
    logic                                load;
    logic                                frag_err;

    proj_onehot_part_decoder u_dec (
        .in_onehot   (in_gfm),
        .out_bits    (part_bits),
        .out_invalid (part_bad)
    );

    // Only the last part can stall, and only while the output register is full and not draining.
    assign in_ready = (part_q != LAST_PART) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign load     = accept && (part_q == LAST_PART);
    assign idx_sum  = in_index + IDX_OFS;

    always_comb begin
        part_d           = part_q;
        asm_d            = asm_q;
        idx_d            = idx_q;
        ref_idx_d        = ref_idx_q;
        err_d            = err_q;
        out_valid_d      = out_valid_q;
        out_fragment_d   = out_fragment_q;
        out_index_d      = out_index_q;
        out_err_d        = out_err_q;
        out_frag_count_d = out_frag_count_q;

        // Part 0 starts a fresh error history; later parts accumulate into it.
        if (part_q == '0) begin
            frag_err = part_bad | idx_sum[SIGNED_INDICE_LEN-1];
        end else begin
            frag_err = err_q | part_bad | (in_index != ref_idx_q);
        end

        if (accept) begin
            part_d = (part_q == LAST_PART) ? '0 : part_q + 1'b1;
            asm_d[FRAG_PART*part_q +: FRAG_PART] = part_bits;
            err_d = frag_err;
            if (part_q == '0) begin
                ref_idx_d = in_index;
                idx_d     = idx_sum[SIGNED_INDICE_LEN-1] ? '0 : idx_sum[INDICE_LEN-1:0];
            end
        end

        if (load) begin
            out_valid_d      = 1'b1;
            out_fragment_d   = asm_d;
            out_index_d      = idx_d;
            out_err_d        = frag_err;
            out_frag_count_d = out_frag_count_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            part_q           <= '0;
            asm_q            <= '0;
            idx_q            <= '0;
            ref_idx_q        <= '0;
            err_q            <= 1'b0;
            out_valid_q      <= 1'b0;
            out_fragment_q   <= '0;
            out_index_q      <= '0;
            out_err_q        <= 1'b0;
            out_frag_count_q <= '0;
        end else begin
            part_q           <= part_d;
            asm_q            <= asm_d;
            idx_q            <= idx_d;
            ref_idx_q        <= ref_idx_d;
            err_q            <= err_d;
            out_valid_q      <= out_valid_d;
            out_fragment_q   <= out_fragment_d;
            out_index_q      <= out_index_d;
            out_err_q        <= out_err_d;
            out_frag_count_q <= out_frag_count_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_fragment   = out_fragment_q;
    assign out_index      = out_index_q;
    assign out_err        = out_err_q;
    assign out_frag_count = out_frag_count_q;
endmodule

// File: tb/tb_proj_gfm_collector.sv
// Randomized bench for proj_gfm_collector: fragments are built as base lists, encoded to
// one-hot parts, and the expected outputs are derived from the base list and index rules.
module tb_proj_gfm_collector;
    import proj_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [63:0]        in_gfm = '0;
    logic signed [10:0] in_index = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [255:0]       out_fragment;
    logic [9:0]         out_index;
    logic               out_err;
    logic [15:0]        out_frag_count;

    always #5 clk = ~clk;

    proj_gfm_collector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_gfm         (in_gfm),
        .in_index       (in_index),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_fragment   (out_fragment),
        .out_index      (out_index),
        .out_err        (out_err),
        .out_frag_count (out_frag_count)
    );

    typedef struct {
        logic [63:0]        gfm;
        logic signed [10:0] idx;
    } part_t;

    typedef struct {
        logic [255:0] frag;
        logic [9:0]   idx;
        logic         err;
    } exp_t;

    part_t       stim_q[$];
    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          parts_seen = 0;
    logic        ov_m = 1'b0;
    logic [15:0] cnt_m = '0;
    int          in_pct = 100;
    int          rdy_pct = 100;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Modes: 0 clean, 1 random bad nibble, 2 random index mismatch, 3 random negative index,
    // 4 ACGT loopback idx 100, 5 partial (4 parts), 6 part3/nibble5 = 0011,
    // 7 idx 44 with 45 on part 5, 8 in_index -57.
    task automatic make_frag(input int mode);
        logic [1:0]         bases [0:127];
        logic [255:0]       frag;
        logic [63:0]        gfm;
        logic [3:0]         nib;
        logic [3:0]         bad_nib;
        logic signed [10:0] base_idx;
        logic signed [10:0] pidx;
        int                 k;
        int                 bad_base;
        int                 mm_p;
        int                 nparts;
        exp_t               e;
        part_t              pt;

        for (int i = 0; i < 128; i++)
            bases[i] = (mode == 4) ? 2'(i % 4) : 2'($urandom_range(0, 3));
        k = (mode == 4 || mode == 7) ? 100 : int'($urandom_range(0, 1023));
        base_idx = 11'(k - 56);
        if (mode == 3) base_idx = 11'(-int'($urandom_range(57, 1024)));
        if (mode == 8) base_idx = -11'sd57;

        bad_base = (mode == 6) ? 3 * 16 + 5 : int'($urandom_range(0, 127));
        do bad_nib = 4'($urandom_range(0, 15)); while ($countones(bad_nib) == 1);
        if (mode == 6) bad_nib = 4'b0011;
        mm_p = int'($urandom_range(1, 7));

        frag = '0;
        for (int i = 0; i < 128; i++)
            if (!((mode == 1 || mode == 6) && i == bad_base)) frag[2*i +: 2] = bases[i];

        nparts = (mode == 5) ? 4 : 8;
        for (int p = 0; p < nparts; p++) begin
            gfm = '0;
            for (int n = 0; n < 16; n++) begin
                nib = 4'b0001 << bases[p*16 + n];
                if ((mode == 1 || mode == 6) && (p*16 + n) == bad_base) nib = bad_nib;
                gfm[4*n +: 4] = nib;
            end
            pidx = base_idx;
            if (mode == 2 && p == mm_p) pidx = base_idx ^ 11'(1 << $urandom_range(0, 10));
            if (mode == 7 && p == 5) pidx = 11'sd45;
            pt.gfm = gfm;
            pt.idx = pidx;
            stim_q.push_back(pt);
        end

        if (mode != 5) begin
            e.frag = frag;
            e.idx  = (mode == 3 || mode == 8) ? 10'd0 : 10'(k);
            e.err  = (mode == 1 || mode == 2 || mode == 3 || mode == 6 || mode == 7 || mode == 8);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_idle();
        int           cycles;
        logic         hold;
        logic [255:0] hf;
        logic [9:0]   hi;
        logic         he;
        logic         last;
        exp_t         e;
        cycles = 0;
        hold = 1'b0;
        hf = '0;
        hi = '0;
        he = 1'b0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (hold) begin
                check_val("hold_fragment", out_fragment, hf);
                check_val("hold_index", 256'(out_index), 256'(hi));
                check_val("hold_err", 256'(out_err), 256'(he));
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            in_valid  = (stim_q.size() > 0) && ($urandom_range(0, 99) < in_pct);
            if (stim_q.size() > 0) begin
                in_gfm   = stim_q[0].gfm;
                in_index = stim_q[0].idx;
            end
            #1;
            check_val("out_valid", 256'(out_valid), 256'(ov_m));
            check_val("frag_count", 256'(out_frag_count), 256'(cnt_m));
            check_val("in_ready", 256'(in_ready), 256'((parts_seen % 8 != 7) || !ov_m || out_ready));
            hold = out_valid && !out_ready;
            hf = out_fragment;
            hi = out_index;
            he = out_err;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_output", 256'(1), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_val("fragment", out_fragment, e.frag);
                    check_val("index", 256'(out_index), 256'(e.idx));
                    check_val("err", 256'(out_err), 256'(e.err));
                end
            end
            last = in_valid && in_ready && (parts_seen % 8 == 7);
            if (in_valid && in_ready) begin
                void'(stim_q.pop_front());
                parts_seen++;
            end
            if (last) begin
                ov_m = 1'b1;
                cnt_m = cnt_m + 16'd1;
            end else if (out_ready) begin
                ov_m = 1'b0;
            end
        end
        if (cycles >= 20000) check_val("timeout", 256'(stim_q.size() + exp_q.size()), 256'(0));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state();
        check_val("rst_out_valid", 256'(out_valid), 256'(0));
        check_val("rst_out_fragment", out_fragment, 256'(0));
        check_val("rst_out_index", 256'(out_index), 256'(0));
        check_val("rst_out_err", 256'(out_err), 256'(0));
        check_val("rst_frag_count", 256'(out_frag_count), 256'(0));
        check_val("rst_in_ready", 256'(in_ready), 256'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state();

        in_pct = 100;
        rdy_pct = 100;
        make_frag(4);
        run_idle();
        check_val("loopback_count", 256'(out_frag_count), 256'(1));

        make_frag(6);
        make_frag(0);
        make_frag(7);
        make_frag(8);
        make_frag(0);
        run_idle();

        in_pct = 100;
        rdy_pct = 20;
        for (int i = 0; i < 30; i++) make_frag(int'($urandom_range(0, 3)));
        run_idle();

        in_pct = 60;
        rdy_pct = 70;
        for (int i = 0; i < 30; i++) make_frag(int'($urandom_range(0, 3)));
        run_idle();

        in_pct = 100;
        rdy_pct = 100;
        make_frag(5);
        run_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state();
        parts_seen = 0;
        ov_m = 1'b0;
        cnt_m = '0;
        make_frag(0);
        make_frag(4);
        run_idle();
        check_val("post_reset_count", 256'(out_frag_count), 256'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
